alu_arbiter: RTL and testbench

// Shares the single combinational alu between two requesters (0: execute stage, 1: branch/address unit).

---
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational alu, registered result
// Fixed priority with starvation limit by default; define ALU_ARB_ROUND_ROBIN_EN for round-robin.
package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_operation_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_CONSECUTIVE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  alu_operation_t        req0_operation,
  input  logic [DATA_WIDTH-1:0] req0_operand_1,
  input  logic [DATA_WIDTH-1:0] req0_operand_2,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  alu_operation_t        req1_operation,
  input  logic [DATA_WIDTH-1:0] req1_operand_1,
  input  logic [DATA_WIDTH-1:0] req1_operand_2,

  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,

  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,

  output alu_operation_t        alu_operation,
  output logic [DATA_WIDTH-1:0] alu_operand_1,
  output logic [DATA_WIDTH-1:0] alu_operand_2,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic                  last_grant_q, last_grant_d;
`else
  logic [3:0]            starve_q, starve_d;
`endif

  logic                  pick1_on_contention;
  logic                  grant0;
  logic                  grant1;
  logic                  rsp_handshake;

  // Winner selection; only meaningful in IDLE, so RESPOND masks both grants.
  always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    pick1_on_contention = ~last_grant_q;
`else
    pick1_on_contention = (starve_q == 4'(MAX_CONSECUTIVE));
`endif
    grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || pick1_on_contention);
    grant0 = (state_q == IDLE) && req0_valid && !grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_operation = ALU_ADD;
    alu_operand_1 = '0;
    alu_operand_2 = '0;
    if (grant0) begin
      alu_operation = req0_operation;
      alu_operand_1 = req0_operand_1;
      alu_operand_2 = req0_operand_2;
    end else if (grant1) begin
      alu_operation = req1_operation;
      alu_operand_1 = req1_operand_1;
      alu_operand_2 = req1_operand_2;
    end
  end

  assign rsp_handshake = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    result_d     = result_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`else
    starve_d     = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = RESPOND;
          owner_d      = grant1;
          result_d     = alu_result;
          rsp0_valid_d = grant0;
          rsp1_valid_d = grant1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_grant_d = grant1;
`else
          // Only req0 wins taken over a waiting req1 count toward starvation.
          if (grant0 && req1_valid) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
`endif
        end
      end
      RESPOND: begin
        if (rsp_handshake) begin
          state_d      = IDLE;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`else
      starve_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      result_q     <= result_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`else
      starve_q     <= starve_d;
`endif
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Arbitration-order expectations follow ALU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  alu_operation_t req0_operation, req1_operation, alu_operation;
  logic [W-1:0]   req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2;
  logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]   rsp0_result, rsp1_result;
  logic [W-1:0]   alu_operand_1, alu_operand_2, alu_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W), .MAX_CONSECUTIVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operation(req0_operation),
    .req0_operand_1(req0_operand_1), .req0_operand_2(req0_operand_2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operation(req1_operation),
    .req1_operand_1(req1_operand_1), .req1_operand_2(req1_operand_2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_operation(alu_operation), .alu_operand_1(alu_operand_1),
    .alu_operand_2(alu_operand_2), .alu_result(alu_result)
  );

  // Behavioural alu standing in for the shared unit.
  always_comb begin
    case (alu_operation)
      ALU_ADD: alu_result = alu_operand_1 + alu_operand_2;
      ALU_SUB: alu_result = alu_operand_1 - alu_operand_2;
      ALU_AND: alu_result = alu_operand_1 & alu_operand_2;
      ALU_OR:  alu_result = alu_operand_1 | alu_operand_2;
      ALU_XOR: alu_result = alu_operand_1 ^ alu_operand_2;
      ALU_SLL: alu_result = alu_operand_1 << alu_operand_2[4:0];
      ALU_SRL: alu_result = alu_operand_1 >> alu_operand_2[4:0];
      ALU_SRA: alu_result = W'($signed(alu_operand_1) >>> alu_operand_2[4:0]);
      default: alu_result = '0;
    endcase
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_operation = ALU_ADD; req1_operation = ALU_ADD;
    req0_operand_1 = '0; req0_operand_2 = '0; req1_operand_1 = '0; req1_operand_2 = '0;
    rst_n = 0;
    #2;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got=%0b exp=0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got=%0b exp=0", rsp1_valid); end
    checks++; if (rsp0_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%0h exp=0", rsp0_result); end
    checks++; if (alu_operation !== ALU_ADD || alu_operand_1 !== 32'd0 || alu_operand_2 !== 32'd0) begin
      errors++; $display("FAIL reset_alu_idle got=%0d/%0h/%0h exp=0/0/0", alu_operation, alu_operand_1, alu_operand_2);
    end
    req0_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle_ready got=%0b%0b exp=10", req0_ready, req1_ready);
    end
    req0_valid = 0;
    next_cycle();
    rst_n = 1;
  endtask

  task automatic test_single();
    req0_operation = ALU_ADD; req0_operand_1 = 32'd5; req0_operand_2 = 32'd7;
    req0_valid = 1; rsp0_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got=%0b exp=1", req0_ready); end
    checks++; if (alu_operation !== ALU_ADD || alu_operand_2 !== 32'd7) begin
      errors++; $display("FAIL single_alu_drive got=%0d/%0h exp=0/7", alu_operation, alu_operand_2);
    end
    next_cycle();
    req0_valid = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL single_rsp_valid got=%0b%0b exp=10", rsp0_valid, rsp1_valid);
    end
    checks++; if (rsp0_result !== 32'd12) begin errors++; $display("FAIL single_result got=%0d exp=12", rsp0_result); end
    next_cycle();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_back_idle got=%0b exp=0", rsp0_valid); end
  endtask

  task automatic test_priority();
    req0_operation = ALU_SUB; req0_operand_1 = 32'd10; req0_operand_2 = 32'd3;
    req1_operation = ALU_XOR; req1_operand_1 = 32'hF0; req1_operand_2 = 32'hFF;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL prio_ready got=%0b%0b exp=10", req0_ready, req1_ready);
    end
    next_cycle();
    req0_valid = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin
      errors++; $display("FAIL prio_rsp0 got=%0b/%0d exp=1/7", rsp0_valid, rsp0_result);
    end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL prio_respond_ready got=%0b exp=0", req1_ready); end
    checks++; if (alu_operation !== ALU_ADD || alu_operand_1 !== 32'd0) begin
      errors++; $display("FAIL prio_respond_alu got=%0d/%0h exp=0/0", alu_operation, alu_operand_1);
    end
    next_cycle();
    checks++; if (req1_ready !== 1'b1 || alu_operation !== ALU_XOR) begin
      errors++; $display("FAIL prio_req1_grant got=%0b/%0d exp=1/4", req1_ready, alu_operation);
    end
    next_cycle();
    req1_valid = 0;
    #1;
    checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_result !== 32'h0F) begin
      errors++; $display("FAIL prio_rsp1 got=%0b%0b/%0h exp=01/f", rsp0_valid, rsp1_valid, rsp1_result);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    req1_operation = ALU_ADD; req1_operand_1 = 32'd100; req1_operand_2 = 32'd23;
    req1_valid = 1; rsp1_ready = 0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_grant got=%0b exp=1", req1_ready); end
    next_cycle();
    req0_operation = ALU_SUB; req0_operand_1 = 32'd9; req0_operand_2 = 32'd4;
    req0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd123) begin
        errors++; $display("FAIL bp_hold_%0d got=%0b/%0d exp=1/123", i, rsp1_valid, rsp1_result);
      end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready_%0d got=%0b%0b exp=00", i, req0_ready, req1_ready);
      end
      next_cycle();
    end
    req1_valid = 0; rsp1_ready = 1; rsp0_ready = 1;
    #1;
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got=%0b exp=1", rsp1_valid); end
    next_cycle();
    checks++; if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got=%0b/%0b exp=0/1", rsp1_valid, req0_ready);
    end
    next_cycle();
    req0_valid = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd5) begin
      errors++; $display("FAIL bp_next_op got=%0b/%0d exp=1/5", rsp0_valid, rsp0_result);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    int got[10];
    int exp_order[10];
    int n;
    int cyc;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    n = 0;
    cyc = 0;
    rst_n = 0;
    #1;
    rst_n = 1;
    req0_operation = ALU_ADD; req0_operand_1 = 32'd2; req0_operand_2 = 32'd3;
    req1_operation = ALU_SRA; req1_operand_1 = 32'hFFFF_FFF8; req1_operand_2 = 32'd1;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    while (n < 10 && cyc < 80) begin
      #1;
      if (req0_ready) begin got[n] = 0; n++; end
      else if (req1_ready) begin got[n] = 1; n++; end
      if (rsp0_valid) begin
        checks++; if (rsp0_result !== 32'd5) begin errors++; $display("FAIL cont_rsp0_result got=%0h exp=5", rsp0_result); end
      end
      if (rsp1_valid) begin
        checks++; if (rsp1_result !== 32'hFFFF_FFFC) begin errors++; $display("FAIL cont_rsp1_result got=%0h exp=fffffffc", rsp1_result); end
      end
      next_cycle();
      cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (n != 10) begin errors++; $display("FAIL cont_timeout grants=%0d exp=10", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] != exp_order[i]) begin
        errors++; $display("FAIL cont_order_%0d got=%0d exp=%0d", i, got[i], exp_order[i]);
      end
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_respond();
    req0_operation = ALU_ADD; req0_operand_1 = 32'd9; req0_operand_2 = 32'd9;
    req0_valid = 1; rsp0_ready = 0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_grant got=%0b exp=1", req0_ready); end
    next_cycle();
    req0_valid = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd18) begin
      errors++; $display("FAIL rst_mid_before got=%0b/%0d exp=1/18", rsp0_valid, rsp0_result);
    end
    #1;
    rst_n = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd0) begin
      errors++; $display("FAIL rst_mid_async got=%0b/%0d exp=0/0", rsp0_valid, rsp0_result);
    end
    #1;
    rst_n = 1;
    next_cycle();
    req0_operand_1 = 32'd1; req0_operand_2 = 32'd1;
    req0_valid = 1; rsp0_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_regrant got=%0b exp=1", req0_ready); end
    next_cycle();
    req0_valid = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2) begin
      errors++; $display("FAIL rst_mid_after got=%0b/%0d exp=1/2", rsp0_valid, rsp0_result);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_contention();
    test_reset_mid_respond();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=done");
    $fatal(1, "watchdog");
  end

endmodule
